// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared op codes, FSM states and decode helpers for the load/store unit
//
// Purpose: constants and small decode functions used by lsu_ctrl and mem_align.
// Ports  : none (package).
package lsu_ctrl_pkg;

  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam logic [3:0] MEM_NONE = 4'h0;
  localparam logic [3:0] MEM_LB   = 4'h1;
  localparam logic [3:0] MEM_LH   = 4'h2;
  localparam logic [3:0] MEM_LW   = 4'h3;
  localparam logic [3:0] MEM_LBU  = 4'h4;
  localparam logic [3:0] MEM_LHU  = 4'h5;
  localparam logic [3:0] MEM_SB   = 4'h6;
  localparam logic [3:0] MEM_SH   = 4'h7;
  localparam logic [3:0] MEM_SW   = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic op_is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: res = addr_lo[0];
      MEM_LW, MEM_SW:          res = (addr_lo != 2'b00);
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_ctrl_mem_align.sv
// rtl/lsu_ctrl_mem_align.sv - byte-lane steering for stores and extract/extend for loads
//
// Purpose: purely combinational lane logic for the load/store unit.
// Ports  : i_op      memory op code
//          i_addr_lo address bits [1:0]
//          i_sdata   store source value
//          i_rdata   raw bus read word
//          o_be      byte enables for the access
//          o_wdata   lane-replicated store data (0 for loads)
//          o_ldata   aligned, sign/zero-extended load result
module mem_align
  import lsu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = ZERO_WORD;
    o_ldata = ZERO_WORD;
    case (i_op)
      MEM_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_sdata[7:0]}};
      end
      MEM_SH: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_sdata[15:0]}};
      end
      MEM_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_sdata;
      end
      MEM_LB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_ldata = {{24{w_byte[7]}}, w_byte};
      end
      MEM_LBU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_ldata = {24'h000000, w_byte};
      end
      MEM_LH: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_ldata = {{16{w_half[15]}}, w_half};
      end
      MEM_LHU: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_ldata = {16'h0000, w_half};
      end
      MEM_LW: begin
        o_be    = 4'b1111;
        o_ldata = i_rdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = ZERO_WORD;
        o_ldata = ZERO_WORD;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - MEM-stage load/store sequencer driving a req/gnt/rvalid data bus
//
// Purpose: stalls the pipeline across each aligned load/store, presents the
//          extracted load data to MEM/WB, passes non-memory ops straight through.
// Ports  : clk, rst (async, active-low)
//          mem_op_i, mem_addr_i, mem_sdata_i        descriptor from EX/MEM
//          reg_waddr_i, reg_we_i, reg_wdata_i       writeback fields from EX/MEM
//          dbus_req_o, dbus_we_o, dbus_addr_o,
//          dbus_be_o, dbus_wdata_o                  registered bus request
//          dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i  bus handshake/response
//          reg_waddr_o, reg_we_o, reg_wdata_o       to MEM/WB
//          stallreq_o, misalign_o, bus_err_o        pipeline control / status
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misalign;
  logic              w_start;
  logic              w_timeout;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ldata;

  // The pipeline is held while the access is in flight, so the EX/MEM
  // inputs stay valid through DONE and can be decoded directly there.
  assign w_is_load  = op_is_load(mem_op_i);
  assign w_is_store = op_is_store(mem_op_i);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = op_is_misaligned(mem_op_i, mem_addr_i[1:0]);
  assign w_start    = w_is_mem & ~w_misalign;
  assign w_timeout  = (r_cnt == TO_LAST);

  mem_align u_mem_align (
    .i_op      (mem_op_i),
    .i_addr_lo (mem_addr_i[1:0]),
    .i_sdata   (mem_sdata_i),
    .i_rdata   (dbus_rdata_i),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ldata   (w_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= ZERO_WORD;
      r_be    <= 4'b0000;
      r_wdata <= ZERO_WORD;
      r_rdata <= ZERO_WORD;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {mem_addr_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_rdata <= ZERO_WORD;
            r_err   <= 1'b0;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (dbus_gnt_i) begin
            r_req <= 1'b0;
          end else if (w_timeout) begin
            r_req <= 1'b0;
            r_err <= 1'b1;
          end
        end
        ST_RESP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (dbus_rvalid_i) begin
            r_rdata <= w_is_load ? w_ldata : ZERO_WORD;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          // Leave the bus quiet between accesses.
          r_we    <= 1'b0;
          r_addr  <= ZERO_WORD;
          r_be    <= 4'b0000;
          r_wdata <= ZERO_WORD;
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_REQ;
      ST_REQ: begin
        if (dbus_gnt_i)     w_next = ST_RESP;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_RESP: begin
        if (dbus_rvalid_i || w_timeout) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The writeback outputs are combinational, so they are forced to their
  // reset values while rst is asserted rather than relying on the state.
  always_comb begin
    reg_waddr_o = NOP_REG_ADDR;
    reg_we_o    = 1'b0;
    reg_wdata_o = ZERO_WORD;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    if (rst != RST_ENABLE) begin
      case (r_state)
        ST_IDLE: begin
          reg_waddr_o = reg_waddr_i;
          reg_wdata_o = reg_wdata_i;
          if (!w_is_mem)       reg_we_o   = reg_we_i;
          else if (w_misalign) misalign_o = 1'b1;
          else                 stallreq_o = 1'b1;
        end
        ST_REQ, ST_RESP: begin
          reg_waddr_o = reg_waddr_i;
          stallreq_o  = 1'b1;
        end
        default: begin
          reg_waddr_o = reg_waddr_i;
          reg_wdata_o = r_rdata;
          reg_we_o    = w_is_load & reg_we_i & ~r_err;
          bus_err_o   = r_err;
        end
      endcase
    end
  end

  assign dbus_req_o   = r_req;
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_be_o    = r_be;
  assign dbus_wdata_o = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  localparam logic [3:0] OP_NONE = 4'h0;
  localparam logic [3:0] OP_LB   = 4'h1;
  localparam logic [3:0] OP_LH   = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_LBU  = 4'h4;
  localparam logic [3:0] OP_LHU  = 4'h5;
  localparam logic [3:0] OP_SB   = 4'h6;
  localparam logic [3:0] OP_SH   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o;
  logic        misalign_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_op_i      (mem_op_i),
    .mem_addr_i    (mem_addr_i),
    .mem_sdata_i   (mem_sdata_i),
    .reg_waddr_i   (reg_waddr_i),
    .reg_we_i      (reg_we_i),
    .reg_wdata_i   (reg_wdata_i),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .reg_waddr_o   (reg_waddr_o),
    .reg_we_o      (reg_we_o),
    .reg_wdata_o   (reg_wdata_o),
    .stallreq_o    (stallreq_o),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the last access, captured at its DONE cycle.
  int          a_stalls;
  int          a_reqs;
  logic [31:0] a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic        a_we;
  logic        a_stable;

  // Starts one access at posedge+1 and returns sampled at the DONE negedge.
  // gnt is given on the gnt_at-th REQ cycle, rvalid on the cycle after.
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int gnt_at, input bit give_gnt);
    bit granted;
    bit answered;
    @(posedge clk);
    #1;
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    granted  = 1'b0;
    answered = 1'b0;
    a_stalls = 0;
    a_reqs   = 0;
    a_stable = 1'b1;
    a_addr   = '0;
    a_be     = '0;
    a_wdata  = '0;
    a_we     = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      if (!stallreq_o) break;
      a_stalls++;
      if (granted && !answered) begin
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rdata;
        answered      = 1'b1;
      end else if (dbus_req_o) begin
        a_reqs++;
        if (a_reqs == 1) begin
          a_addr  = dbus_addr_o;
          a_be    = dbus_be_o;
          a_wdata = dbus_wdata_o;
          a_we    = dbus_we_o;
        end else if (dbus_addr_o !== a_addr || dbus_be_o !== a_be ||
                     dbus_wdata_o !== a_wdata || dbus_we_o !== a_we) begin
          a_stable = 1'b0;
        end
        if (give_gnt && a_reqs == gnt_at) begin
          dbus_gnt_i = 1'b1;
          granted    = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    mem_op_i = OP_NONE;
    @(negedge clk);
  endtask

  task automatic check_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
    run_access(op, addr, 32'h0, rdata, 1, 1'b1);
    check({tag, "_stalls"}, 32'(a_stalls), 32'd3);
    check({tag, "_addr"}, a_addr, {addr[31:2], 2'b00});
    check({tag, "_we_bus"}, 32'(a_we), 32'd0);
    check({tag, "_data"}, reg_wdata_o, exp);
    check({tag, "_reg_we"}, 32'(reg_we_o), 32'd1);
    check({tag, "_waddr"}, 32'(reg_waddr_o), 32'(reg_waddr_i));
  endtask

  task automatic check_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
    run_access(op, addr, sdata, 32'hFFFF_FFFF, 1, 1'b1);
    check({tag, "_be"}, 32'(a_be), 32'(exp_be));
    check({tag, "_wdata"}, a_wdata, exp_wdata);
    check({tag, "_we_bus"}, 32'(a_we), 32'd1);
    check({tag, "_reg_we"}, 32'(reg_we_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    mem_op_i      = OP_NONE;
    mem_addr_i    = 32'h0;
    mem_sdata_i   = 32'h0;
    reg_waddr_i   = 5'd3;
    reg_we_i      = 1'b1;
    reg_wdata_i   = 32'hAAAA_5555;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_we", 32'(reg_we_o), 32'd0);
    check("rst_wdata", reg_wdata_o, 32'h0);
    check("rst_req", 32'(dbus_req_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_be", 32'(dbus_be_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: non-memory pass-through
    reg_waddr_i = 5'd5;
    reg_wdata_i = 32'h1234_5678;
    reg_we_i    = 1'b1;
    @(negedge clk);
    check("pass_wdata", reg_wdata_o, 32'h1234_5678);
    check("pass_we", 32'(reg_we_o), 32'd1);
    check("pass_waddr", 32'(reg_waddr_o), 32'd5);
    check("pass_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    check("pass_req", 32'(dbus_req_o), 32'd0);

    // 2: SB with gnt on 2nd REQ cycle, rvalid one cycle later
    reg_waddr_i = 5'd9;
    run_access(OP_SB, 32'h0100_0003, 32'h0000_00AB, 32'h0, 2, 1'b1);
    check("sb_stalls", 32'(a_stalls), 32'd4);
    check("sb_addr", a_addr, 32'h0100_0000);
    check("sb_be", 32'(a_be), 32'h8);
    check("sb_wdata", a_wdata, 32'hABAB_ABAB);
    check("sb_we_bus", 32'(a_we), 32'd1);
    check("sb_stable", 32'(a_stable), 32'd1);
    check("sb_reg_we", 32'(reg_we_o), 32'd0);
    check("sb_err", 32'(bus_err_o), 32'd0);
    check("sb_req_done", 32'(dbus_req_o), 32'd0);

    check_store("sh_hi", OP_SH, 32'h0000_2002, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    check_store("sw", OP_SW, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // 3: load extraction
    reg_waddr_i = 5'd12;
    check_load("lb", OP_LB, 32'h0000_1002, 32'h0080_0000, 32'hFFFF_FF80);
    check_load("lbu", OP_LBU, 32'h0000_1002, 32'h0080_0000, 32'h0000_0080);
    check_load("lh", OP_LH, 32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001);
    check_load("lhu", OP_LHU, 32'h0000_1000, 32'h1234_F00D, 32'h0000_F00D);
    check_load("lw", OP_LW, 32'h0000_1004, 32'h89AB_CDEF, 32'h89AB_CDEF);
    idle_cycle();
    check("after_load_stall", 32'(stallreq_o), 32'd0);
    check("after_load_we", 32'(reg_we_o), 32'd1);

    // 4: misaligned word load
    @(posedge clk);
    #1;
    mem_op_i   = OP_LW;
    mem_addr_i = 32'h0000_0002;
    @(negedge clk);
    check("mis_flag", 32'(misalign_o), 32'd1);
    check("mis_we", 32'(reg_we_o), 32'd0);
    check("mis_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    check("mis_req", 32'(dbus_req_o), 32'd0);
    idle_cycle();
    check("mis_clear", 32'(misalign_o), 32'd0);

    // 5: timeout with no gnt
    run_access(OP_LW, 32'h0000_0040, 32'h0, 32'h0, 1, 1'b0);
    check("to_reqs", 32'(a_reqs), 32'd64);
    check("to_stalls", 32'(a_stalls), 32'd65);
    check("to_err", 32'(bus_err_o), 32'd1);
    check("to_reg_we", 32'(reg_we_o), 32'd0);
    check("to_req", 32'(dbus_req_o), 32'd0);
    idle_cycle();
    check("to_err_pulse", 32'(bus_err_o), 32'd0);
    check("to_idle_stall", 32'(stallreq_o), 32'd0);

    // 6a: reset while REQ drops dbus_req_o asynchronously
    @(posedge clk);
    #1;
    mem_op_i   = OP_LW;
    mem_addr_i = 32'h0000_0080;
    @(negedge clk);
    @(negedge clk);
    check("rreq_req_before", 32'(dbus_req_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rreq_req", 32'(dbus_req_o), 32'd0);
    check("rreq_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    #1;
    mem_op_i = OP_NONE;
    rst      = 1'b1;

    // 6b: reset while RESP
    @(posedge clk);
    #1;
    mem_op_i = OP_LW;
    @(negedge clk);
    @(negedge clk);
    dbus_gnt_i = 1'b1;
    @(negedge clk);
    dbus_gnt_i = 1'b0;
    check("rresp_stall_before", 32'(stallreq_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rresp_req", 32'(dbus_req_o), 32'd0);
    check("rresp_stall", 32'(stallreq_o), 32'd0);
    check("rresp_we", 32'(reg_we_o), 32'd0);
    @(posedge clk);
    #1;
    mem_op_i = OP_NONE;
    rst      = 1'b1;

    check_load("lw_post_rst", OP_LW, 32'h0000_0080, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
